// File: rtl/regbank_write_ctrl.sv
// regbank_write_ctrl: owns the single write port of the flip-flop register bank.
// Runs a zeroing sweep after reset or on request, then arbitrates round-robin
// between the ALU writeback (A) and load writeback (B) requesters.
module regbank_write_ctrl #(
  parameter int NREGS    = 8,
  parameter int AW       = 3,
  parameter int DW       = 8,
  parameter int ZERO_REG = 1
) (
  input  logic          clock,
  input  logic          clear_n,
  input  logic          init_req,
  input  logic          req_a,
  input  logic [AW-1:0] addr_a,
  input  logic [DW-1:0] data_a,
  input  logic          req_b,
  input  logic [AW-1:0] addr_b,
  input  logic [DW-1:0] data_b,
  output logic          gnt_a,
  output logic          gnt_b,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          init_done
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

  state_e        state, next_state;
  logic [AW-1:0] cnt;
  logic          last_gnt_b;   // 1: B was granted last, so A wins the next tie
  logic          cnt_last;
  logic          any_gnt;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;
  logic          gnt_suppress; // grant to hardwired-zero register retires without writing

  assign cnt_last = (cnt == LAST_ADDR);
  assign busy     = (state == ST_INIT);

  // State register.
  // NOTE: every flop uses <= so all registers sample pre-edge values together.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= ST_INIT;
    else          state <= next_state;
  end

  // Next-state: sweep ends on the last address; init_req is honoured only in ARB.
  // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    unique case (state)
      ST_INIT: if (cnt_last) next_state = ST_ARB;
      ST_ARB:  if (init_req) next_state = ST_INIT;
      default: next_state = ST_INIT;
    endcase
  end

  // Grant decode: no grants while sweeping or while a new sweep is requested.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (state == ST_ARB && !init_req) begin
      if (req_a && req_b) begin
        gnt_a = last_gnt_b;
        gnt_b = !last_gnt_b;
      end else begin
        gnt_a = req_a;
        gnt_b = req_b;
      end
    end
  end

  // Selected write payload for whichever requester won this cycle.
  always_comb begin
    any_gnt  = gnt_a | gnt_b;
    gnt_addr = gnt_a ? addr_a : addr_b;
    gnt_data = gnt_a ? data_a : data_b;
    gnt_suppress = (ZERO_REG != 0) && (gnt_addr == '0);
  end

  // Round-robin pointer: moves only when a grant is actually given.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      last_gnt_b <= 1'b1;
    end else if (any_gnt) begin
      last_gnt_b <= gnt_b;
    end
  end

  // Sweep counter: walks 0..NREGS-1 in INIT, parked at 0 otherwise.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      cnt <= '0;
    end else if (state == ST_INIT) begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Registered write port and end-of-sweep pulse.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      init_done <= 1'b0;
    end else if (state == ST_INIT) begin
      we        <= 1'b1;
      waddr     <= cnt;
      wdata     <= '0;
      init_done <= cnt_last;
    end else begin
      init_done <= 1'b0;
      if (any_gnt) begin
        we    <= !gnt_suppress;
        waddr <= gnt_addr;
        wdata <= gnt_data;
      end else begin
        // Covers init_req too: the port goes quiet until the sweep starts writing.
        we <= 1'b0;
      end
    end
  end

endmodule

// File: doc/regbank_write_ctrl.md
Name: regbank_write_ctrl

Overview:
Controller that owns the single write port of the processor's flip-flop register bank.
- After reset, or on request, it sequences a clear sweep that writes zero to every register.
- Outside the sweep, it shares the write port between two writeback requesters (A: ALU writeback, B: load writeback) with round-robin arbitration.
- Write-port outputs are registered and drive the register bank directly.

Parameters:
NREGS, 8, number of registers in the bank (power of two, >=2)
AW, 3, address width, equal to log2(NREGS)
DW, 8, data width
ZERO_REG, 1, when 1, register 0 is hardwired zero and writes to address 0 are suppressed (init sweep excepted)

Ports:
clock  in  1  system clock, rising edge
clear_n  in  1  reset, asynchronous and active-low
init_req  in  1  request a new clear sweep (level; sampled in ARB only)
req_a  in  1  requester A write request; held with addr_a/data_a stable until gnt_a
addr_a  in  AW  requester A target register
data_a  in  DW  requester A write data
req_b  in  1  requester B write request; same rules as A
addr_b  in  AW  requester B target register
data_b  in  DW  requester B write data
gnt_a  out  1  combinational grant to A, same cycle as accepted request
gnt_b  out  1  combinational grant to B
we  out  1  registered write enable to the register bank
waddr  out  AW  registered write address
wdata  out  DW  registered write data
busy  out  1  high while in INIT (decoded from the state register)
init_done  out  1  registered one-cycle pulse at the end of a sweep

Behaviour:
- Clock and reset: one clock (clock); reset is asynchronous and active-low (clear_n).
- Reset (clear_n=0, asynchronous):
  - state=INIT, sweep counter cnt=0, last-grant pointer=B (so A wins the first tie).
  - we=0, waddr=0, wdata=0, init_done=0, gnt_a=gnt_b=0, busy=1.
- States: INIT, ARB.
- INIT:
  - gnt_a=gnt_b=0.
  - Each rising edge registers we=1, waddr=cnt, wdata=0, then cnt++.
  - On the edge where cnt==NREGS-1, state goes to ARB, cnt goes to 0 and init_done goes to 1.
  - The sweep takes exactly NREGS cycles; init_done is high in the same cycle the last write (waddr=NREGS-1) is on the port.
  - The sweep writes address 0 regardless of ZERO_REG.
  - init_req is ignored in INIT; it does not restart the sweep.
- ARB:
  - init_done returns to 0 one cycle after its pulse.
  - If init_req=1: no grant this cycle; next edge sets state=INIT, cnt=0, we=0. Pending requests stay pending.
  - Else if only one req is high: grant it.
  - Else if both are high: grant the requester that is not the last-grant pointer, then update the pointer to the granted requester. A and B therefore strictly alternate under continuous contention.
  - Else: no grant.
  - Pointer updates only on a grant.
- Write port (ARB, per edge):
  - On a grant: we=1, waddr=granted addr, wdata=granted data. Latency is 1 cycle from grant to we.
  - With ZERO_REG=1 and granted addr==0: the grant is still given (requester retires), but we=0.
  - No grant: we=0; waddr/wdata hold their previous values.
- Requesters may deassert req only after seeing their gnt. A req dropped before its grant is simply not serviced.
- Reset mid-sweep or mid-traffic: outputs go to reset values immediately. After release, a full NREGS-cycle sweep restarts from address 0. No partial write is issued.
- Width rules: cnt is AW bits plus terminal compare; no wrap beyond NREGS-1.

Test Plan:
1. Release clear_n, no requests -> we=1 with waddr 0..7, wdata=0 over 8 consecutive cycles; init_done=1 coincident with waddr=7; busy=1 for the 8 INIT cycles, then 0.
2. After init, req_a=1, addr_a=3, data_a=8'hA5 -> gnt_a=1 same cycle; next cycle we=1, waddr=3, wdata=8'hA5; gnt_b=0.
3. After init, req_a and req_b both held high for 4 cycles -> grants A,B,A,B; we pattern follows with 1-cycle lag and the matching addr/data each cycle.
4. ZERO_REG=1, req_b=1, addr_b=0, data_b=8'hFF -> gnt_b=1 but we=0 next cycle; a subsequent write to addr 1 is granted and written.
5. init_req=1 while req_a pending -> gnt_a=0; 8-cycle sweep follows with busy=1; after init_done, A (still requesting) is granted in the first ARB cycle.
6. Assert clear_n=0 at sweep step 4 -> we=0 and waddr=0 immediately, without waiting for a clock edge; after release the sweep restarts at waddr=0 and runs all 8 writes.
